// File: rtl/rate_cmd_pkg.sv
// Shared constants for the UART rate command controller: ASCII codes, rate codes
// and the 2-bit state encoding.
package rate_cmd_pkg;

  localparam logic [7:0] CH_M_UP = 8'h4D;
  localparam logic [7:0] CH_M_LO = 8'h6D;
  localparam logic [7:0] CH_F_UP = 8'h46;
  localparam logic [7:0] CH_F_LO = 8'h66;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_5    = 8'h35;
  localparam logic [7:0] CH_A_UP = 8'h41;
  localparam logic [7:0] CH_A_LO = 8'h61;
  localparam logic [7:0] CH_K    = 8'h4B;
  localparam logic [7:0] CH_E    = 8'h45;

  localparam logic [1:0] RATE_1 = 2'b00;
  localparam logic [1:0] RATE_5 = 2'b01;
  localparam logic [1:0] RATE_A = 2'b10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GOT_M   = 2'd1;
  localparam logic [1:0] ST_GOT_SEL = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  function automatic logic is_m(input logic [7:0] b);
    return (b == CH_M_UP) || (b == CH_M_LO);
  endfunction

  function automatic logic is_f(input logic [7:0] b);
    return (b == CH_F_UP) || (b == CH_F_LO);
  endfunction

endpackage

// File: rtl/uart_rate_cmd_ctrl_if.sv
// Bundle of UART RX/TX and rate-datapath signals around the command controller.
// RX: irx_data is meaningful only in the cycle irx_valid=1 (no back-pressure).
// TX: otx_start is a one-cycle pulse, issued only in a cycle where itx_busy=0.
interface uart_rate_cmd_ctrl_if;
  logic [7:0] irx_data;
  logic       irx_valid;
  logic       itx_busy;
  logic [7:0] otx_data;
  logic       otx_start;
  logic [1:0] orate_control;
  logic       oSTART;
  logic       ocmd_err;
  logic [1:0] odbg_state;

  modport master (
    output irx_data, irx_valid, itx_busy,
    input  otx_data, otx_start, orate_control, oSTART, ocmd_err, odbg_state
  );

  modport slave (
    input  irx_data, irx_valid, itx_busy,
    output otx_data, otx_start, orate_control, oSTART, ocmd_err, odbg_state
  );
endinterface

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte idle counter; oexpire flags the last allowed idle cycle of a frame.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic oexpire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Raised even when clr is set; the FSM gives a same-cycle byte priority.
  assign oexpire = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_rate_cmd_ctrl.sv
// Parses "M<sel>F" frames from the UART RX strobe, commits a 2-bit rate code and
// answers with 'K' or 'E' on the UART TX.
module uart_rate_cmd_ctrl
  import rate_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rate_cmd_ctrl_if.slave  bus
);

  logic [1:0] state_q, state_d;
  logic [1:0] pending_q, pending_d;
  logic [1:0] rate_q, rate_d;
  logic [7:0] ack_q, ack_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       start_q, start_d;
  logic       err_q, err_d;
  logic       tx_start_q, tx_start_d;
  logic       in_frame, expire, nak;

  assign in_frame = (state_q == ST_GOT_M) || (state_q == ST_GOT_SEL);

  // Held clear outside a frame so every entry into GOT_M starts from zero.
  cmd_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .en      (in_frame),
    .clr     (bus.irx_valid || !in_frame),
    .oexpire (expire)
  );

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    rate_d     = rate_q;
    ack_d      = ack_q;
    tx_data_d  = tx_data_q;
    start_d    = 1'b0;
    err_d      = 1'b0;
    tx_start_d = 1'b0;
    nak        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.irx_valid && is_m(bus.irx_data)) state_d = ST_GOT_M;
      end
      ST_GOT_M: begin
        if (bus.irx_valid) begin
          if (bus.irx_data == CH_1) begin
            pending_d = RATE_1;
            state_d   = ST_GOT_SEL;
          end else if (bus.irx_data == CH_5) begin
            pending_d = RATE_5;
            state_d   = ST_GOT_SEL;
          end else if ((bus.irx_data == CH_A_UP) || (bus.irx_data == CH_A_LO)) begin
            pending_d = RATE_A;
            state_d   = ST_GOT_SEL;
          end else if (!is_m(bus.irx_data)) begin
            nak = 1'b1;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_GOT_SEL: begin
        if (bus.irx_valid) begin
          if (is_f(bus.irx_data)) begin
            rate_d  = pending_q;
            start_d = 1'b1;
            ack_d   = CH_K;
            state_d = ST_ACK;
          end else if (is_m(bus.irx_data)) begin
            state_d = ST_GOT_M;
          end else begin
            nak = 1'b1;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_ACK: begin
        // RX bytes are dropped here; only the TX handshake matters.
        if (!bus.itx_busy) begin
          tx_data_d  = ack_q;
          tx_start_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (nak) begin
      err_d   = 1'b1;
      ack_d   = CH_E;
      state_d = ST_ACK;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= RATE_1;
      rate_q     <= RATE_1;
      ack_q      <= 8'h00;
      tx_data_q  <= 8'h00;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      rate_q     <= rate_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      start_q    <= start_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
    end
  end

  assign bus.otx_data      = tx_data_q;
  assign bus.otx_start     = tx_start_q;
  assign bus.orate_control = rate_q;
  assign bus.oSTART        = start_q;
  assign bus.ocmd_err      = err_q;
  assign bus.odbg_state    = state_q;

endmodule
